wb_regfile: RTL and testbench

- Consumer end of the MEM/WB pipeline register: takes the registered MEM/WB controls, data and destination address, and selects the write-back value.
- Commits that value into the 32x32 general-purpose register file.
- Serves the two ID-stage read ports, with write-to-read bypass so a same-cycle read returns the value being written.
- Keeps a retired-write counter for debug and verification.

---
 rtl/wb_regfile.sv | 88 ++++++++
 tb/tb_wb_regfile.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage plus 32-entry general-purpose register file.
// Selects the MEM/WB write-back value and commits it through a single write
// port. Two ID-stage read ports bypass a same-cycle write (write-first). A
// retired-write counter tracks committed non-zero writes for debug.
//
// Handshake: there is no valid/ready pair. A write is offered whenever
// RegWrite_i is high and is accepted unconditionally on the next rising clk_i,
// unless the destination is register 0 or reset is asserted. WBvalid_o marks
// a cycle in which such a real write is offered.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int CNT_W  = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      RegWrite_i,
    input  logic                      MemtoReg_i,
    input  logic [DATA_W-1:0]         MemData_i,
    input  logic [DATA_W-1:0]         ALUData_i,
    input  logic [$clog2(NREG)-1:0]   RDaddr_i,
    input  logic [$clog2(NREG)-1:0]   RSaddr_i,
    input  logic [$clog2(NREG)-1:0]   RTaddr_i,
    output logic [DATA_W-1:0]         RSdata_o,
    output logic [DATA_W-1:0]         RTdata_o,
    output logic [DATA_W-1:0]         WBdata_o,
    output logic                      WBvalid_o,
    output logic [CNT_W-1:0]          RetireCnt_o
);

    localparam int AW = $clog2(NREG);

    logic [DATA_W-1:0] regs [NREG];
    logic [CNT_W-1:0]  retire_cnt;

    // Write-back value select and real-write qualifier.
    always_comb begin
        WBdata_o  = MemtoReg_i ? MemData_i : ALUData_i;
        WBvalid_o = RegWrite_i && (RDaddr_i != '0);
    end

    // Commit the write-back value; register 0 is never written.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (WBvalid_o) begin
            regs[RDaddr_i] <= WBdata_o;
        end
    end

    // Count committed non-zero writes, wrapping silently.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            retire_cnt <= '0;
        end else if (WBvalid_o) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

    assign RetireCnt_o = retire_cnt;

    // Read port A: zero register, then write-first bypass, then storage.
    always_comb begin
        RSdata_o = '0;
        if (!rst_i || (RSaddr_i == AW'(0))) begin
            RSdata_o = '0;
        end else if (WBvalid_o && (RSaddr_i == RDaddr_i)) begin
            RSdata_o = WBdata_o;
        end else begin
            RSdata_o = regs[RSaddr_i];
        end
    end

    // Read port B: same rules as port A, independent address.
    always_comb begin
        RTdata_o = '0;
        if (!rst_i || (RTaddr_i == AW'(0))) begin
            RTdata_o = '0;
        end else if (WBvalid_o && (RTaddr_i == RDaddr_i)) begin
            RTdata_o = WBdata_o;
        end else begin
            RTdata_o = regs[RTaddr_i];
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: randomized and directed stimulus for wb_regfile, checked
// against an array-based reference model through an expected-response queue.
module tb_wb_regfile;

    localparam int DW    = 32;
    localparam int EXP_W = 4 * DW + 1 + 4;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        rst_i      = 1'b0;
    logic        RegWrite_i = 1'b0;
    logic        MemtoReg_i = 1'b0;
    logic [31:0] MemData_i  = '0;
    logic [31:0] ALUData_i  = '0;
    logic [4:0]  RDaddr_i   = '0;
    logic [4:0]  RSaddr_i   = '0;
    logic [4:0]  RTaddr_i   = '0;
    logic [31:0] RSdata_o, RTdata_o, WBdata_o, RetireCnt_o;
    logic        WBvalid_o;

    logic [31:0] rs_c4, rt_c4, wb_c4;
    logic        valid_c4;
    logic [3:0]  cnt_c4;

    wb_regfile #(.DATA_W(32), .NREG(32), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .RegWrite_i(RegWrite_i),
        .MemtoReg_i(MemtoReg_i), .MemData_i(MemData_i), .ALUData_i(ALUData_i),
        .RDaddr_i(RDaddr_i), .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i),
        .RSdata_o(RSdata_o), .RTdata_o(RTdata_o), .WBdata_o(WBdata_o),
        .WBvalid_o(WBvalid_o), .RetireCnt_o(RetireCnt_o)
    );

    // Narrow-counter instance so counter wrap is reachable in a short run.
    wb_regfile #(.DATA_W(32), .NREG(32), .CNT_W(4)) dut_c4 (
        .clk_i(clk_i), .rst_i(rst_i), .RegWrite_i(RegWrite_i),
        .MemtoReg_i(MemtoReg_i), .MemData_i(MemData_i), .ALUData_i(ALUData_i),
        .RDaddr_i(RDaddr_i), .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i),
        .RSdata_o(rs_c4), .RTdata_o(rt_c4), .WBdata_o(wb_c4),
        .WBvalid_o(valid_c4), .RetireCnt_o(cnt_c4)
    );

    // ---------------- reference model ----------------
    logic [31:0]     m_regs [32];
    longint unsigned m_cnt = 0;

    function automatic logic [31:0] m_read(input logic [4:0] a, input logic rst,
                                           input logic v, input logic [4:0] rd,
                                           input logic [31:0] wb);
        if (!rst || a == 5'd0) return 32'd0;
        if (v && a == rd)      return wb;
        return m_regs[a];
    endfunction

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: the DUT presents a response every cycle; compare mid-cycle.
    always @(negedge clk_i) begin
        logic [EXP_W-1:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rs_data",  RSdata_o,            e[132:101]);
            check("rt_data",  RTdata_o,            e[100:69]);
            check("wb_data",  WBdata_o,            e[68:37]);
            check("wb_valid", {31'd0, WBvalid_o},  {31'd0, e[36]});
            check("retire",   RetireCnt_o,         e[35:4]);
            check("retire4",  {28'd0, cnt_c4},     {28'd0, e[3:0]});
        end
    end

    // ---------------- driver ----------------
    // Applies the previous cycle's commit to the model at the edge, then
    // drives the new inputs and queues the expected response for this cycle.
    task automatic drive(input logic rst, input logic we, input logic m2r,
                         input logic [31:0] md, input logic [31:0] ad,
                         input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        logic [31:0] wb;
        logic        v;
        @(posedge clk_i);
        if (rst_i && RegWrite_i && RDaddr_i != 5'd0) begin
            m_regs[RDaddr_i] = MemtoReg_i ? MemData_i : ALUData_i;
            m_cnt++;
        end
        #1;
        rst_i = rst; RegWrite_i = we; MemtoReg_i = m2r;
        MemData_i = md; ALUData_i = ad;
        RDaddr_i = rd; RSaddr_i = rs; RTaddr_i = rt;
        if (!rst) begin
            foreach (m_regs[i]) m_regs[i] = 32'd0;
            m_cnt = 0;
        end
        wb = m2r ? md : ad;
        v  = we && (rd != 5'd0);
        exp_q.push_back({m_read(rs, rst, v, rd, wb), m_read(rt, rst, v, rd, wb),
                         wb, v, m_cnt[31:0], m_cnt[3:0]});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic        r_we, r_m2r, r_rst;
        logic [4:0]  r_rd, r_rs, r_rt;
        foreach (m_regs[i]) m_regs[i] = 32'd0;

        // Held reset: everything reads zero.
        drive(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        drive(0, 1, 0, 32'h0, 32'h77, 5'd4, 5'd4, 5'd4);

        // Write reg5, then reset asserted mid-cycle with a write pending.
        drive(1, 1, 0, 32'h0, 32'hDEADBEEF, 5'd5, 5'd5, 5'd0);
        drive(0, 1, 0, 32'h0, 32'h12345678, 5'd6, 5'd5, 5'd6);
        drive(1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd6);

        // Write and read back from storage.
        drive(1, 1, 0, 32'h0, 32'h00000011, 5'd3, 5'd0, 5'd0);
        drive(1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd3);

        // Memory select with bypass on both ports.
        drive(1, 1, 1, 32'hCAFEF00D, 32'h1, 5'd7, 5'd7, 5'd7);
        drive(1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd3);

        // Register 0 is never written.
        drive(1, 1, 0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
        drive(1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd7);

        // Write disabled: no bypass, no commit, no count.
        drive(1, 1, 0, 32'h0, 32'h1234, 5'd9, 5'd0, 5'd0);
        drive(1, 0, 0, 32'h0, 32'h5555, 5'd9, 5'd9, 5'd9);
        drive(1, 0, 1, 32'h6666, 32'h0, 5'd9, 5'd9, 5'd3);

        // Back-to-back writes to walk the narrow counter through its wrap.
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, i[0], $urandom, $urandom, 5'(1 + (i % 31)), 5'(1 + (i % 31)), 5'(i % 32));
        end

        // Randomized traffic with occasional reset pulses.
        for (int i = 0; i < 400; i++) begin
            r_rst = ($urandom_range(0, 60) != 0);
            r_we  = ($urandom_range(0, 3) != 0);
            r_m2r = 1'($urandom_range(0, 1));
            r_rd  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            r_rs  = ($urandom_range(0, 3) == 0) ? r_rd : 5'($urandom_range(0, 31));
            r_rt  = ($urandom_range(0, 3) == 0) ? r_rd : 5'($urandom_range(0, 31));
            drive(r_rst, r_we, r_m2r, $urandom, $urandom, r_rd, r_rs, r_rt);
        end

        // Final idle cycle, then let the monitor drain the queue.
        drive(1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd2);
        for (int i = 0; i < 5 && exp_q.size() != 0; i++) begin
            @(negedge clk_i);
            #1;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
